// File: rtl/spi_write_sequencer.sv
// rtl/spi_write_sequencer.sv - two-requester round-robin SPI register-write master (optional shadows: SPI_SEQ_SHADOW_EN)
module spi_write_sequencer #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [6:0] req0_addr,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [6:0] req1_addr,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       SCLK,
    output logic       nCS,
    output logic       COPI,
    output logic       busy,
    output logic       grant_id,
    output logic [7:0] shadow_out_7_0,
    output logic [7:0] shadow_out_15_8,
    output logic [7:0] shadow_pwm_7_0,
    output logic [7:0] shadow_pwm_15_8,
    output logic [7:0] shadow_duty
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_HIGH,
        S_LOW,
        S_TRAIL,
        S_GAP
    } state_t;

    localparam logic [7:0] PH_LAST = 8'(CLK_DIV - 1);

    state_t      state_q;
    logic [7:0]  phase_q;
    logic [4:0]  bit_cnt_q;
    logic [15:0] frame_q;
    logic        last_grant_q;
    logic        grant_id_q;
    logic        sclk_q;
    logic        ncs_q;
    logic        copi_q;

    logic        pick;
    logic        grant;
    logic        phase_done;

    // Round-robin choice: a tie goes to the requester that did not win last time
    always_comb begin
        pick = 1'b0;
        if (req0_valid && req1_valid) begin
            pick = ~last_grant_q;
        end else if (req1_valid) begin
            pick = 1'b1;
        end
    end

    assign grant      = (state_q == S_IDLE) && (req0_valid || req1_valid);
    assign req0_ready = grant && !pick;
    assign req1_ready = grant && pick;
    assign phase_done = (phase_q == 8'd0);

    // Frame sequencer; SCLK/nCS/COPI are driven straight from flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            phase_q      <= 8'd0;
            bit_cnt_q    <= 5'd0;
            frame_q      <= 16'd0;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
            sclk_q       <= 1'b0;
            ncs_q        <= 1'b1;
            copi_q       <= 1'b0;
        end else begin
            if (!phase_done) begin
                phase_q <= phase_q - 8'd1;
            end
            case (state_q)
                S_IDLE: begin
                    if (grant) begin
                        state_q      <= S_LEAD;
                        phase_q      <= PH_LAST;
                        bit_cnt_q    <= 5'd0;
                        frame_q      <= pick ? {1'b1, req1_addr, req1_data}
                                             : {1'b1, req0_addr, req0_data};
                        last_grant_q <= pick;
                        grant_id_q   <= pick;
                        ncs_q        <= 1'b0;
                        copi_q       <= 1'b1;
                    end
                end
                S_LEAD, S_LOW: begin
                    if (phase_done) begin
                        state_q   <= S_HIGH;
                        phase_q   <= PH_LAST;
                        sclk_q    <= 1'b1;
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                    end
                end
                S_HIGH: begin
                    if (phase_done) begin
                        phase_q <= PH_LAST;
                        sclk_q  <= 1'b0;
                        if (bit_cnt_q == 5'd16) begin
                            state_q <= S_TRAIL;
                        end else begin
                            state_q <= S_LOW;
                            frame_q <= {frame_q[14:0], 1'b0};
                            copi_q  <= frame_q[14];
                        end
                    end
                end
                S_TRAIL: begin
                    if (phase_done) begin
                        state_q   <= S_GAP;
                        phase_q   <= PH_LAST;
                        ncs_q     <= 1'b1;
                        copi_q    <= 1'b0;
                        // the idle bit counter doubles as the first/second-half flag of GAP
                        bit_cnt_q <= 5'd0;
                    end
                end
                S_GAP: begin
                    if (phase_done) begin
                        if (bit_cnt_q == 5'd0) begin
                            bit_cnt_q <= 5'd1;
                            phase_q   <= PH_LAST;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign SCLK     = sclk_q;
    assign nCS      = ncs_q;
    assign COPI     = copi_q;
    assign busy     = (state_q != S_IDLE);
    assign grant_id = grant_id_q;

`ifdef SPI_SEQ_SHADOW_EN
    logic [6:0] addr_q;
    logic [7:0] data_q;
    logic [7:0] sh_out_lo_q;
    logic [7:0] sh_out_hi_q;
    logic [7:0] sh_pwm_lo_q;
    logic [7:0] sh_pwm_hi_q;
    logic [7:0] sh_duty_q;
    logic       commit;

    // the shadow only changes once the full frame (all 16 rises plus TRAIL) has gone out
    assign commit = (state_q == S_TRAIL) && phase_done;

    // Latch the granted write and mirror it into the local shadow copy at frame end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= 7'd0;
            data_q      <= 8'd0;
            sh_out_lo_q <= 8'd0;
            sh_out_hi_q <= 8'd0;
            sh_pwm_lo_q <= 8'd0;
            sh_pwm_hi_q <= 8'd0;
            sh_duty_q   <= 8'd0;
        end else begin
            if (grant) begin
                addr_q <= pick ? req1_addr : req0_addr;
                data_q <= pick ? req1_data : req0_data;
            end
            if (commit) begin
                case (addr_q)
                    7'd0:    sh_out_lo_q <= data_q;
                    7'd1:    sh_out_hi_q <= data_q;
                    7'd2:    sh_pwm_lo_q <= data_q;
                    7'd3:    sh_pwm_hi_q <= data_q;
                    7'd4:    sh_duty_q   <= data_q;
                    default: ;
                endcase
            end
        end
    end

    assign shadow_out_7_0  = sh_out_lo_q;
    assign shadow_out_15_8 = sh_out_hi_q;
    assign shadow_pwm_7_0  = sh_pwm_lo_q;
    assign shadow_pwm_15_8 = sh_pwm_hi_q;
    assign shadow_duty     = sh_duty_q;
`else
    assign shadow_out_7_0  = 8'd0;
    assign shadow_out_15_8 = 8'd0;
    assign shadow_pwm_7_0  = 8'd0;
    assign shadow_pwm_15_8 = 8'd0;
    assign shadow_duty     = 8'd0;
`endif

endmodule

// File: tb/tb_spi_write_sequencer.sv
// tb/tb_spi_write_sequencer.sv - self-checking bench for spi_write_sequencer
module tb_spi_write_sequencer;

`ifdef SPI_SEQ_SHADOW_EN
    localparam bit SH_EN = 1'b1;
`else
    localparam bit SH_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic p_rst = 1'b1;
    logic use3 = 1'b0;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT A, CLK_DIV=4
    logic       r0_v = 1'b0, r1_v = 1'b0;
    logic [6:0] r0_a = 7'd0, r1_a = 7'd0;
    logic [7:0] r0_d = 8'd0, r1_d = 8'd0;
    logic       r0_rdy, r1_rdy, a_sclk, a_ncs, a_copi, a_busy, a_gid;
    logic [7:0] a_sh0, a_sh1, a_sh2, a_sh3, a_sh4;

    spi_write_sequencer #(.CLK_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0_v), .req0_addr(r0_a), .req0_data(r0_d), .req0_ready(r0_rdy),
        .req1_valid(r1_v), .req1_addr(r1_a), .req1_data(r1_d), .req1_ready(r1_rdy),
        .SCLK(a_sclk), .nCS(a_ncs), .COPI(a_copi), .busy(a_busy), .grant_id(a_gid),
        .shadow_out_7_0(a_sh0), .shadow_out_15_8(a_sh1), .shadow_pwm_7_0(a_sh2),
        .shadow_pwm_15_8(a_sh3), .shadow_duty(a_sh4)
    );

    // DUT B, CLK_DIV=3
    logic       b_v = 1'b0, b1_v = 1'b0;
    logic [6:0] b_a = 7'd0, b1_a = 7'd0;
    logic [7:0] b_d = 8'd0, b1_d = 8'd0;
    logic       b_rdy, b1_rdy, b_sclk, b_ncs, b_copi, b_busy, b_gid;
    logic [7:0] b_sh0, b_sh1, b_sh2, b_sh3, b_sh4;

    spi_write_sequencer #(.CLK_DIV(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(b_v), .req0_addr(b_a), .req0_data(b_d), .req0_ready(b_rdy),
        .req1_valid(b1_v), .req1_addr(b1_a), .req1_data(b1_d), .req1_ready(b1_rdy),
        .SCLK(b_sclk), .nCS(b_ncs), .COPI(b_copi), .busy(b_busy), .grant_id(b_gid),
        .shadow_out_7_0(b_sh0), .shadow_out_15_8(b_sh1), .shadow_pwm_7_0(b_sh2),
        .shadow_pwm_15_8(b_sh3), .shadow_duty(b_sh4)
    );

    // peripheral model watching whichever DUT is selected
    logic m_sclk, m_ncs, m_copi;
    assign m_sclk = use3 ? b_sclk : a_sclk;
    assign m_ncs  = use3 ? b_ncs  : a_ncs;
    assign m_copi = use3 ? b_copi : a_copi;

    logic [7:0]  p_reg [5];
    logic [15:0] m_sr;
    logic [15:0] m_log [$];
    int m_bits, m_frames, m_ncs_cnt, m_ncs_low, m_run;
    int m_hi_min, m_hi_max, m_lo_min, m_lo_max;
    int rdy0_cnt, rdy1_cnt, rdyb_cnt;
    logic m_sclk_prev, m_ncs_prev;

    task automatic rec_run(input logic lvl, input int n);
        if (lvl) begin
            if (n < m_hi_min) m_hi_min = n;
            if (n > m_hi_max) m_hi_max = n;
        end else begin
            if (n < m_lo_min) m_lo_min = n;
            if (n > m_lo_max) m_lo_max = n;
        end
    endtask

    always @(negedge clk) begin
        if (p_rst) begin
            for (int i = 0; i < 5; i++) p_reg[i] = 8'd0;
            m_sr = 16'd0; m_bits = 0; m_frames = 0; m_ncs_cnt = 0; m_ncs_low = 0; m_run = 0;
            m_hi_min = 999; m_hi_max = 0; m_lo_min = 999; m_lo_max = 0;
            rdy0_cnt = 0; rdy1_cnt = 0; rdyb_cnt = 0;
            m_sclk_prev = 1'b0; m_ncs_prev = 1'b1;
        end else begin
            if (r0_rdy) rdy0_cnt++;
            if (r1_rdy) rdy1_cnt++;
            if (b_rdy)  rdyb_cnt++;
            if (!m_ncs && m_ncs_prev) begin
                m_bits = 0; m_ncs_cnt = 0; m_run = 0;
                m_hi_min = 999; m_hi_max = 0; m_lo_min = 999; m_lo_max = 0;
            end
            if (!m_ncs) begin
                m_ncs_cnt++;
                if (m_run > 0 && m_sclk != m_sclk_prev) begin
                    rec_run(m_sclk_prev, m_run);
                    m_run = 1;
                end else begin
                    m_run++;
                end
                if (m_sclk && !m_sclk_prev) begin
                    m_sr = {m_sr[14:0], m_copi};
                    m_bits++;
                end
            end
            if (m_ncs && !m_ncs_prev) begin
                rec_run(m_sclk_prev, m_run);
                m_ncs_low = m_ncs_cnt;
                if (m_bits == 16) begin
                    m_frames++;
                    m_log.push_back(m_sr);
                    if (m_sr[15] && m_sr[14:8] <= 7'd4) p_reg[int'(m_sr[14:8])] = m_sr[7:0];
                end
            end
            m_sclk_prev = m_sclk;
            m_ncs_prev  = m_ncs;
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] p_pack();
        return {p_reg[4], p_reg[3], p_reg[2], p_reg[1], p_reg[0]};
    endfunction

    // wait for a ready strobe on DUT A (sel 0/1) or DUT B (sel 2); t is the grant cycle
    task automatic wait_ready(input int sel, output int t);
        logic r;
        t = -1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            r = (sel == 0) ? r0_rdy : (sel == 1) ? r1_rdy : b_rdy;
            if (r) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) chk("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idle(input bit on_b, output int t);
        t = -1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (!(on_b ? b_busy : a_busy)) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) chk("idle_timeout", 64'd0, 64'd1);
    endtask

    task automatic chk_phases(input int d);
        chk("sclk_hi_min", 64'(m_hi_min), 64'(d));
        chk("sclk_hi_max", 64'(m_hi_max), 64'(d));
        chk("sclk_lo_min", 64'(m_lo_min), 64'(d));
        chk("sclk_lo_max", 64'(m_lo_max), 64'(d));
    endtask

    typedef struct {
        bit          sel;
        logic [6:0]  addr;
        logic [7:0]  data;
        logic [15:0] exp_frame;
        logic [39:0] exp_regs;   // {duty, pwm_15_8, pwm_7_0, out_15_8, out_7_0}
    } vec_t;

    vec_t vt [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, f0, c0, c1, w;
        int wins [3];
        logic [39:0] sh;

        vt[0] = '{1'b0, 7'h04, 8'hA5, 16'h84A5, 40'hA5_00_00_22_11};
        vt[1] = '{1'b1, 7'h02, 8'h3C, 16'h823C, 40'hA5_00_3C_22_11};
        vt[2] = '{1'b0, 7'h7F, 8'hFF, 16'hFFFF, 40'hA5_00_3C_22_11};
        vt[3] = '{1'b1, 7'h03, 8'h5A, 16'h835A, 40'hA5_5A_3C_22_11};
        vt[4] = '{1'b0, 7'h05, 8'h77, 16'h8577, 40'hA5_5A_3C_22_11};
        vt[5] = '{1'b1, 7'h01, 8'hC3, 16'h81C3, 40'hA5_5A_3C_C3_11};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ncs",   64'(a_ncs),  64'd1);
        chk("rst_sclk",  64'(a_sclk), 64'd0);
        chk("rst_copi",  64'(a_copi), 64'd0);
        chk("rst_busy",  64'(a_busy), 64'd0);
        chk("rst_gid",   64'(a_gid),  64'd0);
        chk("rst_ready", 64'({r0_rdy, r1_rdy}), 64'd0);
        chk("rst_shadow", 64'({a_sh4, a_sh3, a_sh2, a_sh1, a_sh0}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        p_rst = 1'b0;

        // both valid from reset: req0 wins the first tie, then req1
        @(posedge clk); #1;
        r0_v = 1'b1; r0_a = 7'h00; r0_d = 8'h11;
        r1_v = 1'b1; r1_a = 7'h01; r1_d = 8'h22;
        @(negedge clk);
        chk("tie_ready0", 64'(r0_rdy), 64'd1);
        chk("tie_ready1", 64'(r1_rdy), 64'd0);
        @(posedge clk); #1;
        r0_v = 1'b0;
        chk("tie_gid0", 64'(a_gid), 64'd0);
        wait_ready(1, t0);
        @(posedge clk); #1;
        r1_v = 1'b0;
        chk("tie_gid1", 64'(a_gid), 64'd1);
        wait_idle(1'b0, t1);
        chk("tie_frames", 64'(m_frames), 64'd2);
        if (m_log.size() >= 2) begin
            chk("tie_frame0", 64'(m_log[0]), 64'h8011);
            chk("tie_frame1", 64'(m_log[1]), 64'h8122);
        end else begin
            chk("tie_log_size", 64'(m_log.size()), 64'd2);
        end
        chk("tie_regs", 64'(p_pack()), 64'h00_00_00_22_11);
        chk("tie_shadow", 64'({a_sh4, a_sh3, a_sh2, a_sh1, a_sh0}), SH_EN ? 64'h00_00_00_22_11 : 64'd0);

        // table of single writes
        for (int i = 0; i < 6; i++) begin
            f0 = m_frames; c0 = rdy0_cnt; c1 = rdy1_cnt;
            @(posedge clk); #1;
            if (vt[i].sel) begin r1_v = 1'b1; r1_a = vt[i].addr; r1_d = vt[i].data; end
            else           begin r0_v = 1'b1; r0_a = vt[i].addr; r0_d = vt[i].data; end
            wait_ready(int'(vt[i].sel), t0);
            @(posedge clk); #1;
            r0_v = 1'b0; r1_v = 1'b0;
            wait_idle(1'b0, t1);
            chk($sformatf("v%0d_frames", i), 64'(m_frames - f0), 64'd1);
            chk($sformatf("v%0d_frame", i),  64'(m_sr), 64'(vt[i].exp_frame));
            chk($sformatf("v%0d_ncs_low", i), 64'(m_ncs_low), 64'd132);
            chk($sformatf("v%0d_occupancy", i), 64'(t1 - t0), 64'd141);
            chk($sformatf("v%0d_gid", i), 64'(a_gid), 64'(vt[i].sel));
            chk($sformatf("v%0d_ready_cnt", i), 64'({rdy1_cnt - c1, rdy0_cnt - c0}),
                vt[i].sel ? {32'd1, 32'd0} : {32'd0, 32'd1});
            chk($sformatf("v%0d_regs", i), 64'(p_pack()), 64'(vt[i].exp_regs));
            chk($sformatf("v%0d_shadow", i), 64'({a_sh4, a_sh3, a_sh2, a_sh1, a_sh0}),
                SH_EN ? 64'(vt[i].exp_regs) : 64'd0);
            if (i == 0) chk_phases(4);
        end

        // fairness: both held valid across three frames, last winner was req1
        f0 = m_frames;
        @(posedge clk); #1;
        r0_v = 1'b1; r0_a = 7'h06; r0_d = 8'h00;
        r1_v = 1'b1; r1_a = 7'h7E; r1_d = 8'h00;
        for (int k = 0; k < 3; k++) begin
            w = -1;
            for (int c = 0; c < 2000; c++) begin
                @(negedge clk);
                if (r0_rdy || r1_rdy) begin
                    w = r1_rdy ? 1 : 0;
                    break;
                end
            end
            wins[k] = w;
            @(posedge clk); #1;
            if (k == 2) begin r0_v = 1'b0; r1_v = 1'b0; end
        end
        wait_idle(1'b0, t1);
        chk("rr_win0", 64'(wins[0]), 64'd0);
        chk("rr_win1", 64'(wins[1]), 64'd1);
        chk("rr_win2", 64'(wins[2]), 64'd0);
        chk("rr_frames", 64'(m_frames - f0), 64'd3);
        if (m_log.size() >= 3) begin
            chk("rr_frame_a", 64'(m_log[m_log.size() - 3]), 64'h8600);
            chk("rr_frame_b", 64'(m_log[m_log.size() - 2]), 64'hFE00);
            chk("rr_frame_c", 64'(m_log[m_log.size() - 1]), 64'h8600);
        end
        chk("rr_regs", 64'(p_pack()), 64'hA5_5A_3C_C3_11);

        // reset at the 8th SCLK rise aborts the frame cleanly
        f0 = m_frames;
        @(posedge clk); #1;
        r0_v = 1'b1; r0_a = 7'h02; r0_d = 8'h99;
        wait_ready(0, t0);
        @(posedge clk); #1;
        r0_v = 1'b0;
        w = 0;
        for (int c = 0; c < 500; c++) begin
            @(posedge clk);
            if (m_bits >= 8) begin
                w = 1;
                break;
            end
        end
        chk("abort_reached_bit8", 64'(w), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_ncs",  64'(a_ncs),  64'd1);
        chk("abort_sclk", 64'(a_sclk), 64'd0);
        chk("abort_copi", 64'(a_copi), 64'd0);
        chk("abort_busy", 64'(a_busy), 64'd0);
        repeat (2) @(negedge clk);
        chk("abort_ready", 64'(r0_rdy), 64'd0);
        chk("abort_frames", 64'(m_frames - f0), 64'd0);
        chk("abort_regs", 64'(p_pack()), 64'hA5_5A_3C_C3_11);
        chk("abort_shadow", 64'({a_sh4, a_sh3, a_sh2, a_sh1, a_sh0}), 64'd0);
        chk("abort_gid", 64'(a_gid), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        r0_v = 1'b1;
        wait_ready(0, t0);
        @(posedge clk); #1;
        r0_v = 1'b0;
        wait_idle(1'b0, t1);
        chk("retry_frame", 64'(m_sr), 64'h8299);
        chk("retry_frames", 64'(m_frames - f0), 64'd1);
        chk("retry_regs", 64'(p_pack()), 64'hA5_5A_99_C3_11);
        sh = {a_sh4, a_sh3, a_sh2, a_sh1, a_sh0};
        chk("retry_shadow", 64'(sh), SH_EN ? 64'h00_00_99_00_00 : 64'd0);

        // CLK_DIV=3 instance
        use3 = 1'b1;
        f0 = m_frames; c0 = rdyb_cnt;
        @(posedge clk); #1;
        b_v = 1'b1; b_a = 7'h03; b_d = 8'h96;
        wait_ready(2, t0);
        @(posedge clk); #1;
        b_v = 1'b0;
        wait_idle(1'b1, t1);
        chk("d3_frames", 64'(m_frames - f0), 64'd1);
        chk("d3_frame", 64'(m_sr), 64'h8396);
        chk("d3_ncs_low", 64'(m_ncs_low), 64'd99);
        chk("d3_occupancy", 64'(t1 - t0), 64'd106);
        chk("d3_ready_cnt", 64'(rdyb_cnt - c0), 64'd1);
        chk_phases(3);
        chk("d3_reg", 64'(p_reg[3]), 64'h96);
        chk("d3_shadow", 64'(b_sh3), SH_EN ? 64'h96 : 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
